// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store initiator converting sub-word accesses into word reads/writes
// Defining MAU_TRACE_EN prints every memory write as "@pc: *addr <= data".
module mem_access_unit #(
  parameter logic [31:0] ADDR_LIMIT = 32'h00003000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  output logic        dm_we,
  output logic [31:0] dm_pc,
  input  logic [31:0] dm_data
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3, LBU = 3'd4, SW = 3'd5, SH = 3'd6;
  state_t state, state_nxt;
  logic [2:0]  op_q;
  logic [31:0] addr_q, wdata_q, pc_q, word_q, load_val, merged;
  logic [4:0]  bsh, hsh;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        accept, err_in;
  assign req_ready  = state == IDLE;
  assign resp_valid = state == RESP;
  assign dm_we      = state == WRITE;
  assign dm_addr    = {addr_q[31:2], 2'b00};
  assign dm_pc      = pc_q;
  assign accept     = req_valid & req_ready;
  assign bsh        = {addr_q[1:0], 3'b000};
  assign hsh        = {addr_q[1], 4'b0000};
  always_comb begin
    err_in = ((req_op == LW || req_op == SW) && req_addr[1:0] != 2'b00)
          || ((req_op == LH || req_op == LHU || req_op == SH) && req_addr[0])
          || req_addr >= ADDR_LIMIT;
    byte_v = 8'(dm_data >> bsh);
    half_v = 16'(dm_data >> hsh);
    load_val = op_q == LH  ? {{16{half_v[15]}}, half_v}
             : op_q == LHU ? {16'b0, half_v}
             : op_q == LB  ? {{24{byte_v[7]}}, byte_v}
             : op_q == LBU ? {24'b0, byte_v}
             : dm_data;
    merged = op_q == SW ? wdata_q
           : op_q == SH ? (word_q & ~(32'h0000FFFF << hsh)) | ({16'b0, wdata_q[15:0]} << hsh)
           : (word_q & ~(32'h000000FF << bsh)) | ({24'b0, wdata_q[7:0]} << bsh);
    dm_wd = dm_we ? merged : 32'b0;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = err_in ? RESP : req_op == SW ? WRITE : READ;
      READ:    state_nxt = op_q <= LBU ? RESP : WRITE;
      WRITE:   state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      pc_q      <= '0;
      word_q    <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        pc_q    <= req_pc;
      end
      if (state == READ) word_q <= dm_data;
      // response fields change only on entry into RESP, so they hold between responses
      if (state_nxt == RESP && state != RESP) begin
        resp_data <= state == READ ? load_val : 32'b0;
        resp_err  <= state == IDLE;
      end
    end
  end
`ifdef MAU_TRACE_EN
  always @(posedge clk)
    if (dm_we && !reset) $display("@%08h: *%08h <= %08h", dm_pc, dm_addr, dm_wd);
`endif
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench with a word-wide memory model
module tb_mem_access_unit;
  logic        clk = 0, reset = 1, req_valid = 0;
  logic [2:0]  req_op = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, req_pc = 0;
  logic        req_ready, resp_valid, resp_err, dm_we;
  logic [31:0] resp_data, dm_addr, dm_wd, dm_pc, dm_data;
  logic [31:0] mem [0:4095];
  int          errors = 0, checks = 0, wr_cnt = 0;
  logic [31:0] wr_addr, wr_wd, wr_pc;
  mem_access_unit dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_we(dm_we), .dm_pc(dm_pc), .dm_data(dm_data)
  );
  always #5 clk = ~clk;
  assign dm_data = mem[dm_addr[13:2]];
  always @(posedge clk)
    if (dm_we) begin
      mem[dm_addr[13:2]] <= dm_wd;
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= dm_addr;
      wr_wd   <= dm_wd;
      wr_pc   <= dm_pc;
    end
  task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] data, output logic err);
    @(negedge clk);
    req_valid = 1; req_op = op; req_addr = addr; req_wdata = wd; req_pc = 32'h400 + addr;
    @(posedge clk); #1 req_valid = 0;
    lat = 99; data = 'x; err = 'x;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (resp_valid) begin lat = i; data = resp_data; err = resp_err; break; end
    end
  endtask
  task automatic test_reset;
    #1;
    checks++; if ({req_ready, resp_valid, resp_err, dm_we} !== 4'b1000) begin errors++; $display("FAIL reset_ctrl got %b want 1000", {req_ready, resp_valid, resp_err, dm_we}); end
    checks++; if ({resp_data, dm_addr, dm_wd, dm_pc} !== 128'b0) begin errors++; $display("FAIL reset_data got %h want 0", {resp_data, dm_addr, dm_wd, dm_pc}); end
    @(negedge clk); reset = 0;
  endtask
  task automatic test_sw;
    int lat; logic [31:0] d; logic e; int w0;
    w0 = wr_cnt;
    do_req(3'd5, 32'h10, 32'h12345678, lat, d, e);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sw_lat got %0d want 2", lat); end
    checks++; if ({e, d} !== 33'b0) begin errors++; $display("FAIL sw_resp got err=%b data=%h want 0/0", e, d); end
    checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL sw_wcount got %0d want 1", wr_cnt - w0); end
    checks++; if ({wr_addr, wr_wd, wr_pc} !== {32'h10, 32'h12345678, 32'h410}) begin errors++; $display("FAIL sw_write got %h %h %h want 10 12345678 410", wr_addr, wr_wd, wr_pc); end
  endtask
  task automatic test_subword_store;
    int lat; logic [31:0] d; logic e;
    do_req(3'd7, 32'h11, 32'hFFFFFFAB, lat, d, e);
    checks++; if (lat !== 3) begin errors++; $display("FAIL sb_lat got %0d want 3", lat); end
    checks++; if ({wr_addr, wr_wd} !== {32'h10, 32'h1234AB78}) begin errors++; $display("FAIL sb_write got %h %h want 10 1234ab78", wr_addr, wr_wd); end
    do_req(3'd6, 32'h12, 32'h0000BEEF, lat, d, e);
    checks++; if (lat !== 3 || e !== 1'b0) begin errors++; $display("FAIL sh_lat got %0d err=%b want 3 0", lat, e); end
    checks++; if (mem[4] !== 32'hBEEFAB78) begin errors++; $display("FAIL sh_word got %h want beefab78", mem[4]); end
    do_req(3'd7, 32'h2FFF, 32'h55, lat, d, e);
    checks++; if (e !== 1'b0 || mem[3071] !== 32'h55223344) begin errors++; $display("FAIL sb_top got err=%b %h want 0 55223344", e, mem[3071]); end
  endtask
  task automatic test_loads;
    logic [2:0]  ops  [6] = '{3'd3, 3'd4, 3'd1, 3'd2, 3'd0, 3'd3};
    logic [31:0] adrs [6] = '{32'h20, 32'h20, 32'h22, 32'h22, 32'h20, 32'h21};
    logic [31:0] exps [6] = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF8000, 32'h00008000, 32'h8000F0FF, 32'hFFFFFFF0};
    int lat; logic [31:0] d; logic e;
    for (int i = 0; i < 6; i++) begin
      do_req(ops[i], adrs[i], 32'h0, lat, d, e);
      checks++; if ({lat, e, d} !== {32'd2, 1'b0, exps[i]}) begin errors++; $display("FAIL load%0d got lat=%0d err=%b data=%h want 2 0 %h", i, lat, e, d, exps[i]); end
    end
  endtask
  task automatic test_errors;
    logic [2:0]  ops  [3] = '{3'd0, 3'd6, 3'd1};
    logic [31:0] adrs [3] = '{32'h13, 32'h3000, 32'h21};
    int lat; logic [31:0] d; logic e; int w0;
    for (int i = 0; i < 3; i++) begin
      w0 = wr_cnt;
      do_req(ops[i], adrs[i], 32'hFFFF, lat, d, e);
      @(negedge clk);
      checks++; if ({lat, e, d} !== {32'd1, 1'b1, 32'h0}) begin errors++; $display("FAIL err%0d got lat=%0d err=%b data=%h want 1 1 0", i, lat, e, d); end
      checks++; if (wr_cnt !== w0) begin errors++; $display("FAIL err%0d_write got %0d writes want 0", i, wr_cnt - w0); end
    end
  endtask
  task automatic test_reset_mid;
    int w0; int seen;
    w0 = wr_cnt; seen = 0;
    @(negedge clk);
    req_valid = 1; req_op = 3'd6; req_addr = 32'h40; req_wdata = 32'h1111;
    @(posedge clk); #1 req_valid = 0;
    @(negedge clk); reset = 1; #1;
    checks++; if ({req_ready, dm_we} !== 2'b10) begin errors++; $display("FAIL rst_mid got ready/we=%b want 10", {req_ready, dm_we}); end
    @(negedge clk); reset = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (resp_valid || dm_we) seen++;
    end
    checks++; if (seen !== 0 || wr_cnt !== w0) begin errors++; $display("FAIL rst_mid_after got %0d events %0d writes want 0 0", seen, wr_cnt - w0); end
    checks++; if (mem[16] !== 32'hCAFEF00D) begin errors++; $display("FAIL rst_mid_mem got %h want cafef00d", mem[16]); end
  endtask
  task automatic test_back_to_back;
    int lat; logic [31:0] d;
    lat = 99;
    @(negedge clk);
    req_valid = 1; req_op = 3'd5; req_addr = 32'h50; req_wdata = 32'hDEADBEEF;
    @(posedge clk); #1 req_op = 3'd0; req_wdata = 32'h0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (resp_valid) begin lat = i; break; end
    end
    checks++; if (lat !== 2) begin errors++; $display("FAIL b2b_sw_lat got %0d want 2", lat); end
    @(negedge clk);
    checks++; if ({req_ready, resp_valid} !== 2'b10) begin errors++; $display("FAIL b2b_ready got %b want 10", {req_ready, resp_valid}); end
    @(posedge clk); #1 req_valid = 0;
    lat = 99; d = 'x;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (resp_valid) begin lat = i; d = resp_data; break; end
    end
    checks++; if ({lat, d} !== {32'd2, 32'hDEADBEEF}) begin errors++; $display("FAIL b2b_lw got lat=%0d data=%h want 2 deadbeef", lat, d); end
  endtask
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    mem[4] = 32'h12345678;
    mem[8] = 32'h8000F0FF;
    mem[16] = 32'hCAFEF00D;
    mem[3071] = 32'h11223344;
    test_reset;
    test_sw;
    test_subword_store;
    test_loads;
    test_errors;
    test_reset_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
